// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DW    = 32;  // default write-data width
  localparam int NREQ  = 3;   // default number of write-back requesters
  localparam int AW    = 4;   // register number width
  localparam int NREGS = 16;  // architectural registers tracked by the scoreboard

  // Requester indices, lowest index first.
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_LINK = 2;

  // Writing the program counter redirects fetch.
  localparam logic [AW-1:0] REG_PC = 4'hF;

  // One-hot mask for a register number.
  function automatic logic [NREGS-1:0] reg_mask(input logic [AW-1:0] r);
    return NREGS'(1) << r;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin grant logic for the write-back port. PTR names the requester
// scanned first; it advances past each winner and holds when nobody is granted.
module wb_rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] ready
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            idx;

  // Scan from PTR with wrap-around; first valid requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so no latch is inferred.
    ready    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    if (!rst && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && valid[idx]) begin
          found      = 1'b1;
          ready[idx] = 1'b1;
          ptr_next   = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample before any update.
    if (rst) ptr <= '0;
    else     ptr <= ptr_next;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: picks one requester per cycle, registers
// the write for the register file, and keeps a pending-write scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DW   = regfile_wb_arbiter_pkg::DW,
  parameter int NREQ = regfile_wb_arbiter_pkg::NREQ
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ_VALID,
  output logic [NREQ-1:0]    REQ_READY,
  input  logic [4*NREQ-1:0]  REQ_ADDR,
  input  logic [DW*NREQ-1:0] REQ_DATA,
  input  logic               WB_STALL,
  input  logic               RSV_EN,
  input  logic [3:0]         RSV_ADDR,
  output logic               WE,
  output logic [3:0]         WADDR,
  output logic [DW-1:0]      WDATA,
  output logic [15:0]        BUSY,
  output logic               PC_FLUSH
);

  logic          xfer;
  logic [3:0]    sel_addr;
  logic [DW-1:0] sel_data;
  logic [15:0]   set_mask;
  logic [15:0]   clr_mask;

  wb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk  (CLK),
    .rst  (RST),
    .stall(WB_STALL),
    .valid(REQ_VALID),
    .ready(REQ_READY)
  );

  // Select the address and data of the requester that transfers this cycle.
  always_comb begin
    xfer     = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (REQ_VALID[i] && REQ_READY[i]) begin
        xfer     = 1'b1;
        sel_addr = REQ_ADDR[4*i +: 4];
        sel_data = REQ_DATA[DW*i +: DW];
      end
    end
  end

  // Write port register: one cycle after the transfer; address/data hold when idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      WE    <= 1'b0;
      WADDR <= '0;
      WDATA <= '0;
    end else begin
      WE <= xfer;
      if (xfer) begin
        WADDR <= sel_addr;
        WDATA <= sel_data;
      end
    end
  end

  // Scoreboard masks: a reservation at the same edge as a write-back overrides the clear.
  always_comb begin
    set_mask = RSV_EN ? reg_mask(RSV_ADDR) : '0;
    clr_mask = WE ? reg_mask(WADDR) : '0;
  end

  // Pending-write scoreboard.
  always_ff @(posedge CLK) begin
    if (RST) BUSY <= '0;
    else     BUSY <= (BUSY & ~clr_mask) | set_mask;
  end

  assign PC_FLUSH = WE && (WADDR == REG_PC);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int DW   = 32;
  localparam int NREQ = 3;

  logic               clk = 1'b0;
  logic               rst_i;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [4*NREQ-1:0]  req_addr;
  logic [DW*NREQ-1:0] req_data;
  logic               wb_stall;
  logic               rsv_en_i;
  logic [3:0]         rsv_addr_i;
  logic               we;
  logic [3:0]         waddr;
  logic [DW-1:0]      wdata;
  logic [15:0]        busy;
  logic               pc_flush;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
    .CLK      (clk),
    .RST      (rst_i),
    .REQ_VALID(req_valid),
    .REQ_READY(req_ready),
    .REQ_ADDR (req_addr),
    .REQ_DATA (req_data),
    .WB_STALL (wb_stall),
    .RSV_EN   (rsv_en_i),
    .RSV_ADDR (rsv_addr_i),
    .WE       (we),
    .WADDR    (waddr),
    .WDATA    (wdata),
    .BUSY     (busy),
    .PC_FLUSH (pc_flush)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus intent: pending requests (held until granted) and control inputs.
  bit        rv [NREQ];
  bit [3:0]  ra [NREQ];
  bit [31:0] rd [NREQ];
  bit        stall, rsv_en, rst;
  bit [3:0]  rsv_addr;

  // Model state: what the outputs must be in the current cycle.
  int        m_ptr;
  bit        m_we;
  bit [3:0]  m_waddr;
  bit [31:0] m_wdata;
  bit [15:0] m_busy;
  int        last_g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive, compare all outputs to the model, advance the model.
  task automatic cyc();
    int g;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = rv[i];
      req_addr[4*i +: 4]   = ra[i];
      req_data[DW*i +: DW] = rd[i];
    end
    wb_stall   = stall;
    rsv_en_i   = rsv_en;
    rsv_addr_i = rsv_addr;
    rst_i      = rst;
    #2;
    g = -1;
    if (!rst && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (g < 0 && rv[j]) g = j;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("we",        64'(we),        64'(m_we));
    check("waddr",     64'(waddr),     64'(m_waddr));
    check("wdata",     64'(wdata),     64'(m_wdata));
    check("busy",      64'(busy),      64'(m_busy));
    check("pc_flush",  64'(pc_flush),  64'(m_we && m_waddr == 4'hF));
    @(posedge clk);
    if (rst) begin
      m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0; m_ptr = 0;
    end else begin
      if (m_we)   m_busy[m_waddr] = 1'b0;
      if (rsv_en) m_busy[rsv_addr] = 1'b1;
      if (g >= 0) begin
        m_we    = 1'b1;
        m_waddr = ra[g];
        m_wdata = rd[g];
        m_ptr   = (g + 1) % NREQ;
        rv[g]   = 1'b0;
      end else begin
        m_we = 1'b0;
      end
    end
    last_g = g;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Let every pending request complete, then one idle cycle.
  task automatic drain();
    for (int n = 0; n < 10 && (rv[0] || rv[1] || rv[2]); n++) cyc();
    cyc();
  endtask

  initial begin
    req_valid = '0; req_addr = '0; req_data = '0;
    wb_stall = 0; rsv_en_i = 0; rsv_addr_i = 0; rst_i = 1'b1;
    stall = 0; rsv_en = 0; rsv_addr = 0; rst = 0;
    for (int i = 0; i < NREQ; i++) begin rv[i] = 0; ra[i] = 0; rd[i] = 0; end
    m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0; last_g = -1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_we",   64'(we),    64'(0));
    check("reset_busy", 64'(busy),  64'(0));
    check("reset_wdata",64'(wdata), 64'(0));

    // Single ALU write.
    rv[0] = 1; ra[0] = 4'd3; rd[0] = 32'hDEADBEEF;
    cyc();
    check("single_grant", 64'(last_g), 64'(0));
    check("single_we",    64'(we),     64'(1));
    check("single_waddr", 64'(waddr),  64'(3));
    check("single_wdata", 64'(wdata),  64'(32'hDEADBEEF));
    drain();

    // All three continuously valid: strict rotation.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!rv[i]) begin rv[i] = 1; ra[i] = 4'(i + 1); rd[i] = $urandom; end
      cyc();
      check("rr_grant", 64'(last_g), 64'(k % 3));
      check("rr_we",    64'(we),     64'(1));
    end
    drain();

    // Scoreboard reserve / clear / same-edge set-wins.
    rsv_en = 1; rsv_addr = 4'd5;
    cyc();
    rsv_en = 0;
    check("rsv_set", 64'(busy[5]), 64'(1));
    rv[1] = 1; ra[1] = 4'd5; rd[1] = 32'h0000_0555;
    cyc();
    check("rsv_we_cycle", 64'(busy[5]), 64'(1));
    check("rsv_waddr",    64'(waddr),   64'(5));
    cyc();
    check("rsv_clear", 64'(busy[5]), 64'(0));
    rv[1] = 1; ra[1] = 4'd5; rd[1] = 32'h0000_0556;
    cyc();
    rsv_en = 1; rsv_addr = 4'd5;
    cyc();
    rsv_en = 0;
    check("rsv_set_wins", 64'(busy[5]), 64'(1));
    rv[1] = 1; ra[1] = 4'd5; rd[1] = 32'h0000_0557;
    drain();

    // LINK writes R15: one-cycle PC flush.
    rv[2] = 1; ra[2] = 4'hF; rd[2] = 32'h0000_1000;
    cyc();
    check("flush_hi",    64'(pc_flush), 64'(1));
    check("flush_waddr", 64'(waddr),    64'(15));
    cyc();
    check("flush_lo", 64'(pc_flush), 64'(0));

    // Stall holds the pointer.
    do_reset();
    rv[0] = 1; ra[0] = 4'd1; rd[0] = 32'h11;
    cyc();
    stall = 1;
    for (int i = 0; i < NREQ; i++) begin rv[i] = 1; ra[i] = 4'(i + 8); rd[i] = $urandom; end
    repeat (3) begin
      cyc();
      check("stall_grant", 64'(last_g), 64'(-1));
      check("stall_we",    64'(we),     64'(0));
    end
    stall = 0;
    cyc();
    check("post_stall_grant", 64'(last_g), 64'(1));
    drain();

    // Reset in a grant cycle discards the transfer and rewinds the pointer.
    do_reset();
    rsv_en = 1; rsv_addr = 4'd7;
    rv[0] = 1; ra[0] = 4'd2; rd[0] = 32'h22;
    cyc();
    rsv_en = 0;
    rv[0] = 1; ra[0] = 4'd4; rd[0] = 32'h44;
    rv[1] = 1; ra[1] = 4'd6; rd[1] = 32'h66;
    rst = 1;
    cyc();
    rst = 0;
    check("rst_grant", 64'(last_g), 64'(-1));
    check("rst_we",    64'(we),     64'(0));
    check("rst_busy",  64'(busy),   64'(0));
    cyc();
    check("rst_regrant", 64'(last_g), 64'(0));
    drain();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!rv[i] && $urandom_range(1, 0) == 1) begin
          rv[i] = 1; ra[i] = 4'($urandom); rd[i] = $urandom;
        end
      stall    = ($urandom_range(7, 0) == 0);
      rsv_en   = ($urandom_range(2, 0) == 0);
      rsv_addr = 4'($urandom);
      rst      = ($urandom_range(49, 0) == 0);
      cyc();
    end
    stall = 0; rsv_en = 0; rst = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
